// File: rtl/hc_pkg.sv
// Shared definitions for the parametrised 74-series counter family.
package hc_pkg;

  // Direction encoding on the ud input.
  localparam logic HC_UP   = 1'b1;
  localparam logic HC_DOWN = 1'b0;

  // Widest counter the family supports.
  localparam int unsigned HC_MAX_WIDTH = 32;

  // Ceiling log2; hc_clog2(1) = 0, hc_clog2(2**n) = n.
  function automatic int unsigned hc_clog2(input longint unsigned value);
    int unsigned      res;
    longint unsigned  v;
    res = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        res = res + 1;
        v   = v >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hc_counter_mod_if.sv
// Control/data bundle of one counter stage. The master drives the controls
// and the load data; the counter (slave) returns Q, TC and WRAP.
interface hc_counter_mod_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             sr;    // synchronous clear, active-low
  logic             pe;    // parallel load, active-low
  logic             cep;   // count enable, parallel
  logic             cet;   // count enable, trickle (also gates tc)
  logic             ud;    // 1 = up, 0 = down
  logic [WIDTH-1:0] d;     // load data
  logic [WIDTH-1:0] q;     // counter value
  logic             tc;    // terminal count, combinational
  logic             wrap;  // registered wrap pulse

  modport master (
    output sr, pe, cep, cet, ud, d,
    input  q, tc, wrap
  );

  modport slave (
    input  sr, pe, cep, cet, ud, d,
    output q, tc, wrap
  );

endinterface

// File: rtl/hc_cnt_next.sv
// Next-value and wrap-flag generator for a modulo-MODULUS up/down counter.
// Purely combinational; also flags the two terminal positions so callers can
// build TC without repeating the comparisons.
module hc_cnt_next
  import hc_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ud,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  // One extra bit keeps q+1 and MODULUS itself representable at WIDTH=32.
  localparam logic [WIDTH:0]   ModExt = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   OneExt = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TopVal = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] q_inc;
  logic [WIDTH:0] q_dec;

  // Compute both neighbours, then pick by direction.
  always_comb begin
    q_inc   = {1'b0, q} + OneExt;
    q_dec   = {1'b0, q} - OneExt;
    // q+1 >= MODULUS also catches out-of-range loaded values.
    at_max  = (q_inc >= ModExt);
    // Borrow out of the decrement means q was zero.
    at_zero = q_dec[WIDTH];
    nxt     = q;
    wrap    = 1'b0;
    if (ud == HC_UP) begin
      if (at_max) begin
        nxt  = '0;
        wrap = 1'b1;
      end else begin
        nxt  = q_inc[WIDTH-1:0];
      end
    end else begin
      if (at_zero) begin
        nxt  = TopVal;
        wrap = 1'b1;
      end else begin
        nxt  = q_dec[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/hc_counter_mod.sv
// Presettable modulo-N up/down counter, HC161-style. Priority per edge:
// clear, load, count (CEP & CET), hold. TC is combinational for cascading
// (TC -> next stage CET); WRAP is a registered one-cycle pulse after a wrap.
module hc_counter_mod
  import hc_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'(1) << WIDTH
) (
  input  logic             cp,
  input  logic             mr,
  hc_counter_mod_if.slave  bus
);

  localparam logic [WIDTH-1:0] TopVal = WIDTH'(MODULUS - 1);

  // Reject illegal parameter combinations at elaboration.
  if (WIDTH < 1 || WIDTH > HC_MAX_WIDTH) begin : g_bad_width
    $error("hc_counter_mod: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || hc_clog2(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("hc_counter_mod: MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] cnt_nxt;
  logic             cnt_wrap;
  logic             at_max;
  logic             at_zero;

  hc_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_cnt_next (
    .q       (q_q),
    .ud      (bus.ud),
    .nxt     (cnt_nxt),
    .wrap    (cnt_wrap),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  // Priority mux: clear beats load beats count beats hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!bus.sr) begin
      q_d = '0;
    end else if (!bus.pe) begin
      q_d = bus.d;
    end else if (bus.cep && bus.cet) begin
      q_d    = cnt_nxt;
      wrap_d = cnt_wrap;
    end
  end

  // Counter and wrap registers; mr clears both at once, dropping any pending wrap.
  always_ff @(posedge cp or negedge mr) begin
    if (!mr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  // TC ignores cep/pe/sr so a cascade sees the terminal state of this stage alone.
  assign bus.tc   = bus.cet & ((bus.ud == HC_UP) ? at_max : at_zero);

  // A wrap always lands on one of the two ends of the range.
  wrap_lands_on_end : assert property (
    @(posedge cp) disable iff (!mr) wrap_q |-> (q_q == '0 || q_q == TopVal)
  );

endmodule
